// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - digit inputs and segment/anode outputs of the display scanner
interface seven_seg_scan_if;
    logic [15:0] digits;
    logic [3:0]  blink_en;
    logic [3:0]  dp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output digits, blink_en, dp_en,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  digits, blink_en, dp_en,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit common-anode 7-segment scanner with guard blanking and blink
module seven_seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 50000000
) (
    input  logic             master_clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);
    localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [15:0]        snap_digits;
    logic [3:0]         snap_blink;
    logic [3:0]         snap_dp;

    logic        blank_done, show_done, enter_show, stay_show, load, dark;
    logic [1:0]  next_idx;
    logic [15:0] eff_digits;
    logic [3:0]  eff_blink, eff_dp, cur_digit, show_an;
    logic [6:0]  show_seg;
    logic        show_dp;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Outputs are registered, so everything is computed for the digit lit on the next cycle.
    always_comb begin
        blank_done = (GUARD == 0) || (cnt == GUARD_LAST);
        show_done  = (cnt == SCAN_LAST);
        enter_show = 1'b0;
        stay_show  = 1'b0;
        next_idx   = idx;
        if (state == BLANK) begin
            enter_show = blank_done;
        end else if (show_done) begin
            next_idx   = idx + 2'd1;
            enter_show = (GUARD == 0);
        end else begin
            stay_show  = 1'b1;
        end
        load       = enter_show && (next_idx == 2'd0);
        eff_digits = load ? bus.digits   : snap_digits;
        eff_blink  = load ? bus.blink_en : snap_blink;
        eff_dp     = load ? bus.dp_en    : snap_dp;
        cur_digit  = eff_digits[{next_idx, 2'b00} +: 4];
        dark       = !blink_phase && eff_blink[next_idx];
        show_seg   = dark ? 7'h7F : decode(cur_digit);
        show_dp    = dark ? 1'b1  : ~eff_dp[next_idx];
        show_an    = ~(4'b0001 << next_idx);
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state           <= BLANK;
            cnt             <= '0;
            idx             <= 2'd0;
            snap_digits     <= '0;
            snap_blink      <= '0;
            snap_dp         <= '0;
            bus.an          <= 4'b1111;
            bus.seg         <= 7'h7F;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= load;
            if (load) begin
                snap_digits <= bus.digits;
                snap_blink  <= bus.blink_en;
                snap_dp     <= bus.dp_en;
            end
            if (enter_show || stay_show) begin
                bus.an  <= show_an;
                bus.seg <= show_seg;
                bus.dp  <= show_dp;
            end else begin
                bus.an  <= 4'b1111;
                bus.seg <= 7'h7F;
                bus.dp  <= 1'b1;
            end
            case (state)
                BLANK: begin
                    if (blank_done) begin
                        state <= SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        idx   <= next_idx;
                        cnt   <= '0;
                        state <= (GUARD == 0) ? SHOW : BLANK;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

    // Blink timebase runs free of the scan so the blink rate is independent of SCAN_DIV.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
module tb_seven_seg_scan;
    localparam int S = 4;
    localparam int G = 2;
    localparam int B = 40;
    localparam int P = 4 * (S + G);

    logic master_clk = 1'b0;
    logic rst = 1'b0;
    seven_seg_scan_if bus();

    seven_seg_scan #(.SCAN_DIV(S), .GUARD(G), .BLINK_DIV(B)) dut (
        .master_clk (master_clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 master_clk = ~master_clk;

    int errors = 0;
    int checks = 0;
    int t = 0;

    logic [6:0]  seg_table [16];
    logic [15:0] m_digits;
    logic [3:0]  m_blink;
    logic [3:0]  m_dp;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp_en;
        int          t;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge master_clk);
        t++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge master_clk);
        @(negedge master_clk);
        rst = 1'b1;
        t = 0;
    endtask

    task automatic chk_out(input string name, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp);
        chk({name, ".an"}, 32'(bus.an), 32'(an));
        chk({name, ".seg"}, 32'(bus.seg), 32'(seg));
        chk({name, ".dp"}, 32'(bus.dp), 32'(dp));
    endtask

    // Reference: position in the repeating (guard+lit) x 4 schedule, plus a snapshot taken at frame start.
    task automatic model_check();
        int p, slot, off;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fs, dk;
        p    = t % P;
        slot = p / (S + G);
        off  = p % (S + G);
        e_fs = (slot == 0) && (off == G);
        if (e_fs) begin
            m_digits = bus.digits;
            m_blink  = bus.blink_en;
            m_dp     = bus.dp_en;
        end
        if (off < G) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an = 4'hF;
            e_an[slot] = 1'b0;
            dk = m_blink[slot] && ((((t - 1) / B) % 2) == 1);
            e_seg = dk ? 7'h7F : seg_table[m_digits[slot*4 +: 4]];
            e_dp  = dk ? 1'b1 : !m_dp[slot];
        end
        chk_out("rand", e_an, e_seg, e_dp);
        chk("rand.frame_start", 32'(bus.frame_start), 32'(e_fs));
    endtask

    initial begin
        seg_table = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                      7'b0111111};
        vecs[0]  = '{16'h1234, 4'h0,  0, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[1]  = '{16'h1234, 4'h0,  1, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[2]  = '{16'h1234, 4'h0,  2, 4'hE, 7'b0011001,  1'b1, 1'b1};
        vecs[3]  = '{16'h1234, 4'h0,  3, 4'hE, 7'b0011001,  1'b1, 1'b0};
        vecs[4]  = '{16'h1234, 4'h0,  5, 4'hE, 7'b0011001,  1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 4'h0,  6, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 4'h0,  8, 4'hD, 7'b0110000,  1'b1, 1'b0};
        vecs[7]  = '{16'h1234, 4'h0, 14, 4'hB, 7'b0100100,  1'b1, 1'b0};
        vecs[8]  = '{16'h1234, 4'h0, 20, 4'h7, 7'b1111001,  1'b1, 1'b0};
        vecs[9]  = '{16'h1234, 4'h0, 24, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[10] = '{16'h1234, 4'h0, 26, 4'hE, 7'b0011001,  1'b1, 1'b1};
        vecs[11] = '{16'h00AF, 4'h0,  2, 4'hE, 7'b0111111,  1'b1, 1'b1};
        vecs[12] = '{16'h00AF, 4'h0,  8, 4'hD, 7'b0111111,  1'b1, 1'b0};
        vecs[13] = '{16'h00AF, 4'h0, 14, 4'hB, 7'b1000000,  1'b1, 1'b0};
        vecs[14] = '{16'h1234, 4'h4, 14, 4'hB, 7'b0100100,  1'b0, 1'b0};
        vecs[15] = '{16'h1234, 4'h4, 13, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[16] = '{16'h1234, 4'h4,  8, 4'hD, 7'b0110000,  1'b1, 1'b0};
        vecs[17] = '{16'h1234, 4'h4, 17, 4'hB, 7'b0100100,  1'b0, 1'b0};
        vecs[18] = '{16'h1234, 4'h4, 18, 4'hF, 7'h7F,       1'b1, 1'b0};
        vecs[19] = '{16'h9876, 4'h0, 20, 4'h7, 7'b0010000,  1'b1, 1'b0};

        bus.digits = 16'h1234; bus.blink_en = 4'h0; bus.dp_en = 4'h0;

        for (int i = 0; i < 20; i++) begin
            bus.digits = vecs[i].digits;
            bus.dp_en  = vecs[i].dp_en;
            bus.blink_en = 4'h0;
            do_reset();
            run_to(vecs[i].t);
            chk_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp);
            chk($sformatf("vec%0d.frame_start", i), 32'(bus.frame_start), 32'(vecs[i].fs));
        end

        // Asynchronous reset while digit 2 is lit, then restart from digit 0.
        bus.digits = 16'h1234; bus.dp_en = 4'h4;
        do_reset();
        run_to(15);
        chk_out("pre_rst", 4'hB, 7'b0100100, 1'b0);
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 4'hF, 7'h7F, 1'b1);
        chk("async_rst.frame_start", 32'(bus.frame_start), 32'd0);
        @(negedge master_clk);
        rst = 1'b1;
        t = 0;
        step();
        chk_out("rst_guard", 4'hF, 7'h7F, 1'b1);
        step();
        chk_out("rst_first", 4'hE, 7'b0011001, 1'b1);
        chk("rst_first.frame_start", 32'(bus.frame_start), 32'd1);
        step();
        chk("rst_fs_pulse", 32'(bus.frame_start), 32'd0);

        // Input change mid-frame is held off until the next frame.
        bus.digits = 16'h1234; bus.dp_en = 4'h0;
        do_reset();
        run_to(9);
        bus.digits = 16'h5678;
        run_to(14); chk("snap.d2", 32'(bus.seg), 32'(7'b0100100));
        run_to(20); chk("snap.d3", 32'(bus.seg), 32'(7'b1111001));
        run_to(26); chk("snap.new_d0", 32'(bus.seg), 32'(7'b0000000));
        chk("snap.fs", 32'(bus.frame_start), 32'd1);
        run_to(32); chk("snap.new_d1", 32'(bus.seg), 32'(7'b1111000));

        // Blink on digit 0 only.
        bus.digits = 16'h1234; bus.blink_en = 4'b0001;
        do_reset();
        run_to(26); chk_out("blink.on1", 4'hE, 7'b0011001, 1'b1);
        run_to(50); chk_out("blink.off1", 4'hE, 7'h7F, 1'b1);
        run_to(56); chk_out("blink.d1", 4'hD, 7'b0110000, 1'b1);
        run_to(74); chk_out("blink.off2", 4'hE, 7'h7F, 1'b1);
        run_to(98); chk_out("blink.on2", 4'hE, 7'b0011001, 1'b1);

        // Random inputs against the reference model.
        bus.digits = 16'($urandom); bus.blink_en = 4'($urandom); bus.dp_en = 4'($urandom);
        m_digits = '0; m_blink = '0; m_dp = '0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            step();
            model_check();
            if ($urandom_range(0, 7) == 0) begin
                bus.digits   = 16'($urandom);
                bus.blink_en = 4'($urandom);
                bus.dp_en    = 4'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
